// File: rtl/ppm16_pkg.sv
// rtl/ppm16_pkg.sv - shared 16-PPM link constants, shared by ppm16_mod and ppm16_demod
// Contents: sync header symbols, header lengths, chips per symbol and the FSM state encoding.
package ppm16_pkg;

  localparam int SYNC_LEN     = 4;
  localparam int LEN_SYMS     = 2;
  localparam int SYMBOL_CHIPS = 16;

  localparam logic [3:0] SYNC_SYMBOLS [SYNC_LEN] = '{4'h0, 4'hF, 4'h5, 4'hA};

  typedef logic [1:0] ppm_state_t;
  localparam ppm_state_t ST_IDLE = 2'd0;
  localparam ppm_state_t ST_SYNC = 2'd1;
  localparam ppm_state_t ST_LEN  = 2'd2;
  localparam ppm_state_t ST_DATA = 2'd3;

  function automatic logic [3:0] sync_symbol(input logic [1:0] idx);
    return SYNC_SYMBOLS[idx];
  endfunction

endpackage

// File: rtl/ppm16_symbol_shaper.sv
// rtl/ppm16_symbol_shaper.sv - pulse position and symbol timing flags for one 16-PPM symbol
// Ports:
//   sym           in   4  symbol being sent
//   chip_cnt      in   CHIP_W  current chip (guard chips follow chip 15 when present)
//   chip_bit_cnt  in   3  clk cycle within the current chip
//   pulse         out  1  current chip is the pulse chip of sym
//   chip_end      out  1  last clk cycle of the current chip
//   last_chip     out  1  current chip is the last chip of the symbol period
//   boundary      out  1  last clk cycle of the symbol period
module ppm16_symbol_shaper #(
  parameter int CHIP_BITS = 2,
  parameter int CHIP_W    = 4,
  parameter int LAST_CHIP = 15
) (
  input  logic [3:0]        sym,
  input  logic [CHIP_W-1:0] chip_cnt,
  input  logic [2:0]        chip_bit_cnt,
  output logic              pulse,
  output logic              chip_end,
  output logic              last_chip,
  output logic              boundary
);

  // Guard chips are numbered 16 and above, so they can never match a 4-bit symbol.
  assign pulse     = (chip_cnt == CHIP_W'(sym));
  assign chip_end  = (chip_bit_cnt == 3'(CHIP_BITS - 1));
  assign last_chip = (chip_cnt == CHIP_W'(LAST_CHIP));
  assign boundary  = chip_end & last_chip;

endmodule

// File: rtl/ppm16_mod.sv
// rtl/ppm16_mod.sv - transmit-side 16-PPM packet modulator (SYNC, LEN, DATA framing)
// Optional guard chips after every symbol: define PPM16_MOD_GUARD_EN.
// Ports:
//   clk          in   1  clock, posedge
//   reset        in   1  asynchronous active-high reset
//   tx_start     in   1  packet start, sampled only when idle
//   data_len     in   8  data symbol count, latched on the accepted tx_start
//   din          in   4  next data symbol
//   din_valid    in   1  din holds a symbol
//   din_ready    out  1  din is taken this cycle if din_valid (combinational)
//   dout         out  1  serial chip bit, registered
//   dout_valid   out  1  high for every cycle of the packet, registered
//   tx_busy      out  1  FSM not idle
//   tx_done      out  1  pulse in the cycle after the last packet bit
//   tx_underrun  out  1  pulse when data was missing at a symbol boundary
module ppm16_mod
  import ppm16_pkg::*;
#(
  parameter int CHIP_BITS   = 2,
  parameter int GUARD_CHIPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] data_len,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       dout,
  output logic       dout_valid,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

`ifdef PPM16_MOD_GUARD_EN
  localparam int CHIP_W    = 5;
  localparam int LAST_CHIP = SYMBOL_CHIPS - 1 + GUARD_CHIPS;
`else
  localparam int CHIP_W    = 4;
  localparam int LAST_CHIP = SYMBOL_CHIPS - 1;
`endif

  if (CHIP_BITS < 1 || CHIP_BITS > 8) begin : g_bad_chip_bits
    $error("ppm16_mod: CHIP_BITS must be 1..8");
  end
  if (GUARD_CHIPS < 1 || GUARD_CHIPS > 15) begin : g_bad_guard_chips
    $error("ppm16_mod: GUARD_CHIPS must be 1..15");
  end

  ppm_state_t        state;
  logic [7:0]        len_reg;
  logic [3:0]        sym_reg;
  logic [7:0]        sym_cnt;
  logic [CHIP_W-1:0] chip_cnt;
  logic [2:0]        chip_bit_cnt;

  logic pulse, chip_end, last_chip, boundary;
  logic in_pkt, accept, more_data, underrun;

  ppm16_symbol_shaper #(
    .CHIP_BITS (CHIP_BITS),
    .CHIP_W    (CHIP_W),
    .LAST_CHIP (LAST_CHIP)
  ) u_shaper (
    .sym          (sym_reg),
    .chip_cnt     (chip_cnt),
    .chip_bit_cnt (chip_bit_cnt),
    .pulse        (pulse),
    .chip_end     (chip_end),
    .last_chip    (last_chip),
    .boundary     (boundary)
  );

  assign in_pkt  = (state != ST_IDLE);
  assign tx_busy = in_pkt;

  // The FSM is already idle while the final bit is still on dout; dout_valid and
  // tx_done hold off a new start until the cycle after tx_done.
  assign accept = (state == ST_IDLE) & tx_start & ~dout_valid & ~tx_done;

  assign more_data = ({1'b0, sym_cnt} + 9'd1) < {1'b0, len_reg};

  assign din_ready = boundary &
                     (((state == ST_LEN) & (sym_cnt == 8'(LEN_SYMS - 1)) & (len_reg != 8'd0)) |
                      ((state == ST_DATA) & more_data));

  assign underrun = din_ready & ~din_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      len_reg      <= '0;
      sym_reg      <= '0;
      sym_cnt      <= '0;
      chip_cnt     <= '0;
      chip_bit_cnt <= '0;
      dout         <= 1'b0;
      dout_valid   <= 1'b0;
      tx_done      <= 1'b0;
      tx_underrun  <= 1'b0;
    end else begin
      // Outputs lag the counters by one cycle; an underrun suppresses the
      // final bit of the symbol that was ending.
      dout        <= in_pkt & ~underrun & pulse;
      dout_valid  <= in_pkt & ~underrun;
      tx_done     <= dout_valid & ~in_pkt;
      tx_underrun <= underrun;

      if (state == ST_IDLE) begin
        if (accept) begin
          state        <= ST_SYNC;
          len_reg      <= data_len;
          sym_reg      <= sync_symbol(2'd0);
          sym_cnt      <= '0;
          chip_cnt     <= '0;
          chip_bit_cnt <= '0;
        end
      end else begin
        if (chip_end) begin
          chip_bit_cnt <= '0;
          chip_cnt     <= last_chip ? '0 : chip_cnt + CHIP_W'(1);
        end else begin
          chip_bit_cnt <= chip_bit_cnt + 3'd1;
        end

        if (boundary) begin
          case (state)
            ST_SYNC: begin
              if (sym_cnt == 8'(SYNC_LEN - 1)) begin
                state   <= ST_LEN;
                sym_cnt <= '0;
                sym_reg <= len_reg[7:4];
              end else begin
                sym_cnt <= sym_cnt + 8'd1;
                sym_reg <= sync_symbol(sym_cnt[1:0] + 2'd1);
              end
            end
            ST_LEN: begin
              if (sym_cnt != 8'(LEN_SYMS - 1)) begin
                sym_cnt <= sym_cnt + 8'd1;
                sym_reg <= len_reg[3:0];
              end else if (len_reg == 8'd0 || !din_valid) begin
                state   <= ST_IDLE;
                sym_cnt <= '0;
              end else begin
                state   <= ST_DATA;
                sym_cnt <= '0;
                sym_reg <= din;
              end
            end
            default: begin
              if (!more_data || !din_valid) begin
                state   <= ST_IDLE;
                sym_cnt <= '0;
              end else begin
                sym_cnt <= sym_cnt + 8'd1;
                sym_reg <= din;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ppm16_mod.sv
// tb/tb_ppm16_mod.sv - randomized self-checking bench for ppm16_mod against a packet-level model
module tb_ppm16_mod;

  localparam int CB = 2;
  localparam int GC = 4;
`ifdef PPM16_MOD_GUARD_EN
  localparam int SP = (16 + GC) * CB;
`else
  localparam int SP = 16 * CB;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] data_len;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready, dout, dout_valid, tx_busy, tx_done, tx_underrun;

  ppm16_mod #(.CHIP_BITS(CB), .GUARD_CHIPS(GC)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_start    (tx_start),
    .data_len    (data_len),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_underrun (tx_underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int pkt_no   = 0;
  logic [3:0] pkt_data [$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int exp_sym(input int s, input int len);
    int sync_tab [4];
    sync_tab = '{0, 15, 5, 10};
    if (s < 4) return sync_tab[s];
    if (s == 4) return len / 16;
    if (s == 5) return len % 16;
    if (s - 6 < pkt_data.size()) return int'(pkt_data[s - 6]);
    return 0;
  endfunction

  // Bit j of the packet stream: pulse when the chip number equals the symbol.
  function automatic int exp_bit(input int j, input int len);
    return (((j % SP) / CB) == exp_sym(j / SP, len)) ? 1 : 0;
  endfunction

  task automatic fill(input int n);
    pkt_data.delete();
    for (int k = 0; k < n; k++) pkt_data.push_back(4'($urandom));
  endtask

  task automatic run_pkt(input int len, input int under_u, input bit mid_start,
                         input bit start_at_done, input int reset_at);
    int  t_len, stop, last_valid, idx, k;
    bit  und;
    int  e_valid, e_dout, e_busy, e_done, e_under, e_ready;
    t_len      = (6 + len) * SP;
    und        = (under_u >= 0);
    stop       = und ? (6 + under_u) * SP : t_len;
    last_valid = und ? stop - 1 : t_len;
    idx        = 0;
    @(negedge clk);
    tx_start = 1'b1;
    data_len = 8'(len);
    for (int i = 0; i <= stop + 3; i++) begin
      @(negedge clk);
      if (i == 0) tx_start = 1'b0;
      if (i == 1) data_len = 8'($urandom);
      if (reset_at == i) begin
        reset = 1'b1;
        #1;
        check($sformatf("p%0d async_reset dout", pkt_no), dout, 0);
        check($sformatf("p%0d async_reset dout_valid", pkt_no), dout_valid, 0);
        check($sformatf("p%0d async_reset tx_busy", pkt_no), tx_busy, 0);
        check($sformatf("p%0d async_reset din_ready", pkt_no), din_ready, 0);
        check($sformatf("p%0d async_reset tx_done", pkt_no), tx_done, 0);
        check($sformatf("p%0d async_reset tx_underrun", pkt_no), tx_underrun, 0);
        reset = 1'b0;
        din_valid = 1'b0;
        pkt_no++;
        return;
      end
      e_valid = (i >= 1 && i <= last_valid) ? 1 : 0;
      e_dout  = e_valid ? exp_bit(i - 1, len) : 0;
      e_busy  = (i < stop) ? 1 : 0;
      e_done  = (!und && i == t_len + 1) ? 1 : 0;
      e_under = (und && i == stop) ? 1 : 0;
      k       = (i + 1) / SP;
      e_ready = (((i + 1) % SP) == 0 && k >= 6 && k <= 5 + len && i < stop) ? 1 : 0;
      check($sformatf("p%0d dout c%0d", pkt_no, i), dout, e_dout);
      check($sformatf("p%0d dout_valid c%0d", pkt_no, i), dout_valid, e_valid);
      check($sformatf("p%0d tx_busy c%0d", pkt_no, i), tx_busy, e_busy);
      check($sformatf("p%0d tx_done c%0d", pkt_no, i), tx_done, e_done);
      check($sformatf("p%0d tx_underrun c%0d", pkt_no, i), tx_underrun, e_under);
      check($sformatf("p%0d din_ready c%0d", pkt_no, i), din_ready, e_ready);

      if (din_ready) begin
        if (idx == under_u) begin
          din_valid = 1'b0;
        end else begin
          din_valid = 1'b1;
          din = (idx < pkt_data.size()) ? pkt_data[idx] : 4'h0;
          idx++;
        end
      end else begin
        din_valid = 1'($urandom);
        din = 4'($urandom);
      end

      if (mid_start && i == 40) tx_start = 1'b1;
      if (mid_start && i == 41) tx_start = 1'b0;
      if (start_at_done && !und && i == t_len) tx_start = 1'b1;
      if (start_at_done && !und && i == t_len + 2) tx_start = 1'b0;
    end
    tx_start  = 1'b0;
    din_valid = 1'b0;
    pkt_no++;
  endtask

  initial begin
    int len, u;
    reset = 1'b1;
    tx_start = 1'b0;
    data_len = 8'd0;
    din = 4'd0;
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset dout", dout, 0);
    check("reset dout_valid", dout_valid, 0);
    check("reset tx_busy", tx_busy, 0);
    check("reset tx_done", tx_done, 0);
    check("reset tx_underrun", tx_underrun, 0);
    check("reset din_ready", din_ready, 0);
    reset = 1'b0;

    pkt_data = '{4'h7, 4'h0, 4'hF};
    run_pkt(3, -1, 1'b0, 1'b0, -1);
    pkt_data = '{4'h7};
    run_pkt(1, -1, 1'b0, 1'b0, -1);
    pkt_data.delete();
    run_pkt(0, -1, 1'b0, 1'b1, -1);
    fill(4);
    run_pkt(4, 1, 1'b0, 1'b0, -1);
    fill(3);
    run_pkt(3, 0, 1'b0, 1'b0, -1);
    fill(3);
    run_pkt(3, -1, 1'b1, 1'b0, -1);
    fill(5);
    run_pkt(5, -1, 1'b0, 1'b0, 6 * SP + 10);
    fill(3);
    run_pkt(3, -1, 1'b0, 1'b1, -1);

    for (int n = 0; n < 8; n++) begin
      len = $urandom_range(0, 12);
      u = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      fill(len);
      run_pkt(len, u, 1'($urandom), 1'($urandom), -1);
    end

    fill(255);
    run_pkt(255, -1, 1'b0, 1'b1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
